// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signal bundle for mem_arbiter.
// The arbiter takes the slave modport; requesters and memory model take master.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [DATA_WIDTH-1:0] if_rdata_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic                  d_byte_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic                  d_gnt_o;
    logic                  d_rvalid_o;
    logic [DATA_WIDTH-1:0] d_rdata_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic                  mem_byte_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_we_i, d_byte_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_en_o, mem_we_o, mem_byte_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_we_i, d_byte_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_en_o, mem_we_o, mem_byte_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (read-only) and data (load/store) requesters.
// Optional MEM_ARB_PERF_EN adds saturating per-requester wait-cycle counters.
//
// state | meaning
// IDLE  | no transaction in flight; grants a pending request combinationally
// BUSY  | memory access in progress; latency counter runs down to 0
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]  perf_if_wait_o,
    output logic [31:0]  perf_d_wait_o
`endif
);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(MEM_LATENCY - 1);
    localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIMIT);

    if (MEM_LATENCY < 1) begin : g_lat_chk
        $error("mem_arbiter: MEM_LATENCY must be >= 1");
    end
    if (STARVE_LIMIT < 1) begin : g_starve_chk
        $error("mem_arbiter: STARVE_LIMIT must be >= 1");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  owner_q, owner_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_byte_q, mem_byte_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  d_rvalid_q, d_rvalid_d;
    logic                  if_gnt, d_gnt;
    logic                  starve_full;

    assign starve_full = (starve_q == STARVE_MX);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_byte_d  = mem_byte_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;

        case (state_q)
            IDLE: begin
                // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
                if (bus.if_req_i && (!bus.d_req_i || starve_full)) begin
                    if_gnt = 1'b1;
                end else if (bus.d_req_i) begin
                    d_gnt = 1'b1;
                end

                if (if_gnt) begin
                    owner_d     = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_byte_d  = 1'b0;
                    mem_addr_d  = bus.if_addr_i;
                    mem_wdata_d = '0;
                end else if (d_gnt) begin
                    owner_d     = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_we_i;
                    mem_byte_d  = bus.d_byte_i;
                    mem_addr_d  = bus.d_addr_i;
                    mem_wdata_d = bus.d_wdata_i;
                end

                if (if_gnt || d_gnt) begin
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end

                if (if_gnt || !bus.if_req_i) begin
                    starve_d = '0;
                end else if (d_gnt && !starve_full) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_byte_d  = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_we_q ? '0 : bus.mem_rdata_i;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_byte_q  <= mem_byte_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    // Grants are combinational, so mask them while reset is asserted.
    assign bus.if_gnt_o    = if_gnt & rst;
    assign bus.d_gnt_o     = d_gnt & rst;
    assign bus.if_rvalid_o = if_rvalid_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.d_rvalid_o  = d_rvalid_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_byte_o  = mem_byte_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_d_q, perf_d_d;

    always_comb begin
        perf_if_d = perf_if_q;
        perf_d_d  = perf_d_q;
        if (bus.if_req_i && !if_gnt && (perf_if_q != '1)) begin
            perf_if_d = perf_if_q + 1'b1;
        end
        if (bus.d_req_i && !d_gnt && (perf_d_q != '1)) begin
            perf_d_d = perf_d_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_q <= '0;
            perf_d_q  <= '0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_d_q  <= perf_d_d;
        end
    end

    assign perf_if_wait_o = perf_if_q;
    assign perf_d_wait_o  = perf_d_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4).
// Perf counter checks are compiled in when MEM_ARB_PERF_EN is defined.
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LAT = 2;
    localparam int NV = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_wait;
    logic [31:0] perf_d_wait;
`endif

    mem_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_wait_o(perf_if_wait),
        .perf_d_wait_o(perf_d_wait)
`endif
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic        d_byte;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] mem_rdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_if_rvalid;
        logic        e_d_rvalid;
        logic        e_mem_en;
        logic        e_mem_we;
        logic        e_mem_byte;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic [31:0] e_if_rdata;
        logic [31:0] e_d_rdata;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.d_req_i     = 1'b0;
        bus.d_we_i      = 1'b0;
        bus.d_byte_i    = 1'b0;
        bus.d_addr_i    = '0;
        bus.d_wdata_i   = '0;
        bus.mem_rdata_i = '0;
    endtask

    // Leaves the bench just after a negedge with reset released.
    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int   gcyc[$];
        logic gkind[$];
        logic [5:0] exp_kind;

        drive_idle();
        rst = 1'b0;

        // Single fetch, byte store, simultaneous requests with a withdrawn request.
        vecs[0]  = '{1, 32'h10, 0,0,0, 0, 0, 0,          1,0,0,0, 0,0,0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0,      0,0,0, 0, 0, 0,          0,0,0,0, 1,0,0, 32'h10, 0, 0, 0};
        vecs[2]  = '{0, 0,      0,0,0, 0, 0, 32'hDEADBEEF, 0,0,0,0, 1,0,0, 32'h10, 0, 0, 0};
        vecs[3]  = '{0, 0,      0,0,0, 0, 0, 0,          0,0,1,0, 0,0,0, 0, 0, 32'hDEADBEEF, 0};
        vecs[4]  = '{0, 0,      0,0,0, 0, 0, 0,          0,0,0,0, 0,0,0, 0, 0, 32'hDEADBEEF, 0};
        vecs[5]  = '{0, 0,      1,1,1, 32'h103, 32'hAB, 32'h55555555, 0,1,0,0, 0,0,0, 0, 0, 32'hDEADBEEF, 0};
        vecs[6]  = '{0, 0,      0,0,0, 0, 0, 32'h55555555, 0,0,0,0, 1,1,1, 32'h103, 32'hAB, 32'hDEADBEEF, 0};
        vecs[7]  = '{0, 0,      0,0,0, 0, 0, 32'h55555555, 0,0,0,0, 1,1,1, 32'h103, 32'hAB, 32'hDEADBEEF, 0};
        vecs[8]  = '{0, 0,      0,0,0, 0, 0, 32'h55555555, 0,0,0,1, 0,0,0, 0, 0, 32'hDEADBEEF, 0};
        vecs[9]  = '{1, 32'h20, 1,0,0, 32'h200, 0, 0,    0,1,0,0, 0,0,0, 0, 0, 32'hDEADBEEF, 0};
        vecs[10] = '{1, 32'h20, 0,0,0, 0, 0, 0,          0,0,0,0, 1,0,0, 32'h200, 0, 32'hDEADBEEF, 0};
        vecs[11] = '{1, 32'h20, 0,0,0, 0, 0, 32'h12345678, 0,0,0,0, 1,0,0, 32'h200, 0, 32'hDEADBEEF, 0};
        vecs[12] = '{1, 32'h20, 0,0,0, 0, 0, 0,          1,0,0,1, 0,0,0, 0, 0, 32'hDEADBEEF, 32'h12345678};
        vecs[13] = '{0, 0,      1,1,0, 32'h400, 32'h99, 0, 0,0,0,0, 1,0,0, 32'h20, 0, 32'hDEADBEEF, 32'h12345678};
        vecs[14] = '{0, 0,      0,0,0, 0, 0, 32'hCAFEF00D, 0,0,0,0, 1,0,0, 32'h20, 0, 32'hDEADBEEF, 32'h12345678};
        vecs[15] = '{0, 0,      0,0,0, 0, 0, 0,          0,0,1,0, 0,0,0, 0, 0, 32'hCAFEF00D, 32'h12345678};

        #12;
        chk("rst_mem_en", bus.mem_en_o, 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_if_rvalid", bus.if_rvalid_o, 0);
        chk("rst_d_rvalid", bus.d_rvalid_o, 0);
        chk("rst_if_rdata", bus.if_rdata_o, 0);
        chk("rst_d_rdata", bus.d_rdata_o, 0);
        bus.if_req_i = 1'b1;
        #1;
        chk("rst_if_gnt_masked", bus.if_gnt_o, 0);
        bus.if_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.if_req_i    = vecs[i].if_req;
            bus.if_addr_i   = vecs[i].if_addr;
            bus.d_req_i     = vecs[i].d_req;
            bus.d_we_i      = vecs[i].d_we;
            bus.d_byte_i    = vecs[i].d_byte;
            bus.d_addr_i    = vecs[i].d_addr;
            bus.d_wdata_i   = vecs[i].d_wdata;
            bus.mem_rdata_i = vecs[i].mem_rdata;
            #2;
            chk($sformatf("r%0d_if_gnt", i), bus.if_gnt_o, vecs[i].e_if_gnt);
            chk($sformatf("r%0d_d_gnt", i), bus.d_gnt_o, vecs[i].e_d_gnt);
            chk($sformatf("r%0d_if_rvalid", i), bus.if_rvalid_o, vecs[i].e_if_rvalid);
            chk($sformatf("r%0d_d_rvalid", i), bus.d_rvalid_o, vecs[i].e_d_rvalid);
            chk($sformatf("r%0d_mem_en", i), bus.mem_en_o, vecs[i].e_mem_en);
            chk($sformatf("r%0d_mem_we", i), bus.mem_we_o, vecs[i].e_mem_we);
            chk($sformatf("r%0d_mem_byte", i), bus.mem_byte_o, vecs[i].e_mem_byte);
            chk($sformatf("r%0d_mem_addr", i), bus.mem_addr_o, vecs[i].e_mem_addr);
            chk($sformatf("r%0d_mem_wdata", i), bus.mem_wdata_o, vecs[i].e_mem_wdata);
            chk($sformatf("r%0d_if_rdata", i), bus.if_rdata_o, vecs[i].e_if_rdata);
            chk($sformatf("r%0d_d_rdata", i), bus.d_rdata_o, vecs[i].e_d_rdata);
        end

        // Starvation: both requests held; expect D D D D F D, one grant every LAT+1 cycles.
        do_reset();
        bus.d_req_i   = 1'b1;
        bus.d_addr_i  = 32'h300;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h30;
        for (int c = 0; c < 60 && gkind.size() < 6; c++) begin
            #2;
            chk($sformatf("starve_c%0d_dual_gnt", c), bus.if_gnt_o & bus.d_gnt_o, 0);
            if (bus.d_gnt_o) begin
                gkind.push_back(1'b1);
                gcyc.push_back(c);
            end else if (bus.if_gnt_o) begin
                gkind.push_back(1'b0);
                gcyc.push_back(c);
            end
            @(negedge clk);
        end
        chk("starve_grant_count", gkind.size(), 6);
        exp_kind = 6'b101111;
        for (int i = 0; i < gkind.size(); i++) begin
            chk($sformatf("starve_g%0d_is_data", i), gkind[i], exp_kind[i]);
            if (i > 0) chk($sformatf("starve_g%0d_gap", i), gcyc[i] - gcyc[i-1], LAT + 1);
        end

        // Reset during BUSY: abandoned, no rvalid afterwards, next request served normally.
        do_reset();
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h500;
        #2;
        chk("rstb_d_gnt", bus.d_gnt_o, 1);
        @(negedge clk);
        drive_idle();
        bus.mem_rdata_i = 32'h77;
        #2;
        chk("rstb_busy_mem_en", bus.mem_en_o, 1);
        rst = 1'b0;
        #1;
        chk("rstb_mem_en_cleared", bus.mem_en_o, 0);
        chk("rstb_mem_addr_cleared", bus.mem_addr_o, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            chk($sformatf("rstb_c%0d_no_d_rvalid", c), bus.d_rvalid_o, 0);
            chk($sformatf("rstb_c%0d_no_if_rvalid", c), bus.if_rvalid_o, 0);
            chk($sformatf("rstb_c%0d_d_rdata", c), bus.d_rdata_o, 0);
            @(negedge clk);
        end
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h60;
        #2;
        chk("rstb_if_gnt", bus.if_gnt_o, 1);
        @(negedge clk);
        bus.if_req_i = 1'b0;
        #2;
        chk("rstb_if_mem_addr", bus.mem_addr_o, 32'h60);
        @(negedge clk);
        bus.mem_rdata_i = 32'h600D;
        @(negedge clk);
        bus.mem_rdata_i = '0;
        #2;
        chk("rstb_if_rvalid", bus.if_rvalid_o, 1);
        chk("rstb_if_rdata", bus.if_rdata_o, 32'h600D);

`ifdef MEM_ARB_PERF_EN
        // Fetch waits behind two data transactions: 6 blocked cycles; data waits 2.
        do_reset();
        bus.d_req_i   = 1'b1;
        bus.d_addr_i  = 32'h700;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h70;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) bus.d_req_i = 1'b0;
            if (c == 7) bus.if_req_i = 1'b0;
            #2;
            if (c == 3) chk("perf_second_d_gnt", bus.d_gnt_o, 1);
            if (c == 6) chk("perf_if_gnt", bus.if_gnt_o, 1);
            if (c == 7) begin
                chk("perf_if_wait", perf_if_wait, 6);
                chk("perf_d_wait", perf_d_wait, 2);
            end
            @(negedge clk);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
